pulse_width_demod: RTL and testbench

PULSE_WIDTH_DEMOD -- requirements
Module: pulse_width_demod

---
 rtl/bep_pkg.sv | 18 +
 rtl/line_sync.sv | 52 +++++
 rtl/pulse_width_demod.sv | 169 ++++++++++++++++
 tb/tb_pulse_width_demod.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bep_pkg.sv
// Shared definitions for the burst/edge pulse decoders: FSM state encoding
// and default timing constants, also used by the downstream field decoder.
package bep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_ABORT = 2'd3
    } bep_state_e;

    localparam int BEP_MIN_PULSE  = 8;
    localparam int BEP_THRESH     = 40;
    localparam int BEP_MAX_PULSE  = 120;
    localparam int BEP_GAP_CYCLES = 400;
    localparam int BEP_CNT_W      = 10;

endpackage

// File: rtl/line_sync.sv
// Input conditioning for the pulse-width line: 2-FF synchronizer, optionally
// followed by a 3-sample majority filter (PULSE_WIDTH_DEMOD_GLITCH_FILTER_EN).
// The filter delays both edges by 2 cycles, so pulse widths are preserved
// while single-cycle glitches never reach a 2-of-3 majority.
module line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic s_o
);

    logic meta_q;
    logic sync_q;

    // Two-flop synchronizer for the asynchronous raw line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

`ifdef PULSE_WIDTH_DEMOD_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       maj;

    // Majority vote over the current and two previous synchronized samples
    always_comb begin
        maj = (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    // Sample history and registered filter output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_q};
            filt_q <= maj;
        end
    end

    assign s_o = filt_q;
`else
    assign s_o = sync_q;
`endif

endmodule

// File: rtl/pulse_width_demod.sv
// Pulse-width demodulator: measures high widths of the synchronized line,
// decodes short/long pulses as 0/1 and frames them by long low gaps.
// Optional macro: PULSE_WIDTH_DEMOD_GLITCH_FILTER_EN (majority filter in line_sync).
module pulse_width_demod
    import bep_pkg::*;
#(
    parameter int MIN_PULSE  = BEP_MIN_PULSE,
    parameter int THRESH     = BEP_THRESH,
    parameter int MAX_PULSE  = BEP_MAX_PULSE,
    parameter int GAP_CYCLES = BEP_GAP_CYCLES,
    parameter int CNT_W      = BEP_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digital_in,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_error,
    output logic [7:0] bit_count,
    output logic       busy
);

    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] THR_C      = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(GAP_CYCLES - 1);

    logic             s;
    bep_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             started_q, started_d;
    logic [7:0]       bit_count_q, bit_count_d;
    logic             valid_q, valid_d;
    logic             data_q, data_d;
    logic             start_q, start_d;
    logic             end_q, end_d;
    logic             err_q, err_d;
    logic             emit;
    logic             emit_bit;

    line_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (digital_in),
        .s_o    (s)
    );

    // State, counter and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            started_q   <= 1'b0;
            bit_count_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            started_q   <= started_d;
            bit_count_q <= bit_count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            start_q     <= start_d;
            end_q       <= end_d;
            err_q       <= err_d;
        end
    end

    // Next-state decode: width measurement, gap timing and bit emission
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        started_d   = started_q;
        bit_count_d = bit_count_q;
        valid_d     = 1'b0;
        data_d      = 1'b0;
        start_d     = 1'b0;
        end_d       = 1'b0;
        err_d       = 1'b0;
        emit        = 1'b0;
        emit_bit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d   = ST_HIGH;
                    cnt_d     = ONE_C;
                    started_d = 1'b0;
                end
            end
            ST_HIGH: begin
                if (s) begin
                    if (cnt_q == MAX_C) begin
                        err_d   = 1'b1;
                        state_d = ST_ABORT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    // The edge that sees the line low is already the first low sample
                    cnt_d = ONE_C;
                    if (cnt_q < MIN_C) begin
                        err_d   = 1'b1;
                        state_d = ST_ABORT;
                    end else begin
                        emit     = 1'b1;
                        emit_bit = (cnt_q >= THR_C);
                        state_d  = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = ONE_C;
                end else if (cnt_q == GAP_LAST_C) begin
                    end_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            ST_ABORT: begin
                if (s) begin
                    cnt_d = '0;
                end else if (cnt_q == GAP_LAST_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (emit) begin
            valid_d = 1'b1;
            data_d  = emit_bit;
            if (!started_q) begin
                start_d     = 1'b1;
                started_d   = 1'b1;
                bit_count_d = 8'd1;
            end else if (bit_count_q != 8'hFF) begin
                bit_count_d = bit_count_q + 8'd1;
            end
        end
    end

    assign bit_valid   = valid_q;
    assign bit_data    = data_q;
    assign frame_start = start_q;
    assign frame_end   = end_q;
    assign frame_error = err_q;
    assign bit_count   = bit_count_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_width_demod.sv
// Directed bench for pulse_width_demod; honours PULSE_WIDTH_DEMOD_GLITCH_FILTER_EN.
module tb_pulse_width_demod;

    localparam int MIN_PULSE  = 8;
    localparam int THRESH     = 40;
    localparam int MAX_PULSE  = 120;
    localparam int GAP_CYCLES = 400;
    localparam int CNT_W      = 10;
`ifdef PULSE_WIDTH_DEMOD_GLITCH_FILTER_EN
    localparam int LAT = 5;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digital_in;
    logic       bit_valid, bit_data, frame_start, frame_end, frame_error, busy;
    logic [7:0] bit_count;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_valid = 0, n_start = 0, n_end = 0, n_err = 0, n_both = 0, n_start_alone = 0;
    int last_valid_cyc = 0, last_start_cyc = 0, last_end_cyc = 0, last_err_cyc = 0;
    logic bit_log [0:255];

    pulse_width_demod #(
        .MIN_PULSE  (MIN_PULSE),
        .THRESH     (THRESH),
        .MAX_PULSE  (MAX_PULSE),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digital_in  (digital_in),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frame_error (frame_error),
        .bit_count   (bit_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge away from DUT updates
    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin
            if (n_valid < 256) bit_log[n_valid[7:0]] = bit_data;
            n_valid = n_valid + 1;
            last_valid_cyc = cyc;
        end
        if (frame_start === 1'b1) begin
            n_start = n_start + 1;
            last_start_cyc = cyc;
            if (bit_valid !== 1'b1) n_start_alone = n_start_alone + 1;
        end
        if (frame_end === 1'b1) begin
            n_end = n_end + 1;
            last_end_cyc = cyc;
        end
        if (frame_error === 1'b1) begin
            n_err = n_err + 1;
            last_err_cyc = cyc;
        end
        if (frame_end === 1'b1 && frame_error === 1'b1) n_both = n_both + 1;
    end

    task automatic send_high(input int w);
        digital_in = 1'b1;
        repeat (w) @(negedge clk);
        digital_in = 1'b0;
    endtask

    task automatic send_low(input int l);
        digital_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        digital_in = 1'b0;
        repeat (3) @(negedge clk);
        digital_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({bit_valid, bit_data, frame_start, frame_end, frame_error, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000000", {bit_valid, bit_data, frame_start, frame_end, frame_error, busy}); end
        checks++; if (bit_count !== 8'd0) begin
            errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
        digital_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_low(10);
        checks++; if (busy !== 1'b0 || n_valid + n_err + n_start + n_end != 0) begin
            errors++; $display("FAIL reset_release_idle: got busy=%b events=%0d expected busy=0 events=0", busy, n_valid + n_err + n_start + n_end); end
    endtask

    task automatic test_basic();
        int v0 = n_valid, s0 = n_start, e0 = n_end, r0 = n_err;
        int fall_cyc, first_valid;
        int idx;
        logic [3:0] got;
        send_high(20); fall_cyc = cyc; send_low(30);
        first_valid = last_valid_cyc;
        checks++; if (first_valid - fall_cyc != LAT) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", first_valid - fall_cyc, LAT); end
        checks++; if (n_start - s0 != 1 || last_start_cyc != first_valid) begin
            errors++; $display("FAIL basic_start_with_first_bit: got starts=%0d at %0d expected 1 at %0d", n_start - s0, last_start_cyc, first_valid); end
        send_high(60); send_low(30);
        send_high(20); send_low(30);
        send_high(60); send_low(GAP_CYCLES + 10);
        got = 4'b0;
        for (int k = 0; k < 4; k++) begin
            idx = v0 + k;
            got[k] = bit_log[idx[7:0]];
        end
        checks++; if (n_valid - v0 != 4 || got !== 4'b1010) begin
            errors++; $display("FAIL basic_bits: got n=%0d bits(b3..b0)=%b expected n=4 bits=1010", n_valid - v0, got); end
        checks++; if (n_end - e0 != 1 || n_err - r0 != 0) begin
            errors++; $display("FAIL basic_frame_end: got end=%0d err=%0d expected end=1 err=0", n_end - e0, n_err - r0); end
        checks++; if (bit_count !== 8'd4 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_count_idle: got count=%0d busy=%b expected count=4 busy=0", bit_count, busy); end
    endtask

    task automatic test_widths();
        int widths [5]  = '{7, 8, 39, 40, 120};
        int exp_err [5] = '{1, 0, 0, 0, 0};
        int exp_bit [5] = '{0, 0, 0, 1, 1};
        int v0, s0, e0, r0, idx;
        logic [7:0] bc0;
        for (int i = 0; i < 5; i++) begin
            v0 = n_valid; s0 = n_start; e0 = n_end; r0 = n_err; bc0 = bit_count;
            send_high(widths[i]); send_low(GAP_CYCLES + 10);
            idx = v0;
            checks++; if (n_err - r0 != exp_err[i] || n_valid - v0 != 1 - exp_err[i]) begin
                errors++; $display("FAIL width_%0d_class: got err=%0d bits=%0d expected err=%0d bits=%0d", widths[i], n_err - r0, n_valid - v0, exp_err[i], 1 - exp_err[i]); end
            if (exp_err[i] == 1) begin
                checks++; if (n_start - s0 != 0 || n_end - e0 != 0 || bit_count !== bc0) begin
                    errors++; $display("FAIL width_%0d_no_frame: got start=%0d end=%0d count=%0d expected 0 0 %0d", widths[i], n_start - s0, n_end - e0, bit_count, bc0); end
            end else begin
                checks++; if (bit_log[idx[7:0]] !== exp_bit[i][0] || bit_count !== 8'd1 || n_start - s0 != 1 || n_end - e0 != 1) begin
                    errors++; $display("FAIL width_%0d_bit: got bit=%b count=%0d start=%0d end=%0d expected bit=%0d count=1 start=1 end=1", widths[i], bit_log[idx[7:0]], bit_count, n_start - s0, n_end - e0, exp_bit[i]); end
            end
        end
    endtask

    task automatic test_overlong();
        int v0 = n_valid, e0 = n_end, r0 = n_err;
        int rise_cyc;
        logic [7:0] bc0 = bit_count;
        digital_in = 1'b1; rise_cyc = cyc;
        repeat (130) @(negedge clk);
        digital_in = 1'b0;
        checks++; if (n_err - r0 != 1 || last_err_cyc - rise_cyc != LAT + MAX_PULSE) begin
            errors++; $display("FAIL overlong_error: got err=%0d at +%0d expected 1 at +%0d", n_err - r0, last_err_cyc - rise_cyc, LAT + MAX_PULSE); end
        send_low(300);
        checks++; if (busy !== 1'b1 || n_valid - v0 != 0) begin
            errors++; $display("FAIL overlong_abort_hold: got busy=%b bits=%0d expected busy=1 bits=0", busy, n_valid - v0); end
        send_low(110);
        checks++; if (busy !== 1'b0 || n_valid - v0 != 0 || n_end - e0 != 0 || bit_count !== bc0) begin
            errors++; $display("FAIL overlong_recover: got busy=%b bits=%0d end=%0d count=%0d expected 0 0 0 %0d", busy, n_valid - v0, n_end - e0, bit_count, bc0); end
    endtask

    task automatic test_gap_boundary();
        int v0 = n_valid, s0 = n_start, e0 = n_end;
        int fall_cyc, idx;
        send_high(20); send_low(GAP_CYCLES - 1);
        send_high(60);
        checks++; if (n_end - e0 != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL gap_399_continues: got end=%0d busy=%b expected end=0 busy=1", n_end - e0, busy); end
        fall_cyc = cyc;
        send_low(GAP_CYCLES + 10);
        idx = v0 + 1;
        checks++; if (n_valid - v0 != 2 || n_start - s0 != 1 || bit_count !== 8'd2 || bit_log[idx[7:0]] !== 1'b1) begin
            errors++; $display("FAIL gap_frame_bits: got bits=%0d start=%0d count=%0d expected 2 1 2", n_valid - v0, n_start - s0, bit_count); end
        checks++; if (n_end - e0 != 1 || last_end_cyc - fall_cyc != LAT + GAP_CYCLES - 1) begin
            errors++; $display("FAIL gap_400_ends: got end=%0d at +%0d expected 1 at +%0d", n_end - e0, last_end_cyc - fall_cyc, LAT + GAP_CYCLES - 1); end
    endtask

    task automatic test_reset_midframe();
        int v0, s0, e0, r0, idx;
        send_high(20); send_low(30); send_high(60); send_low(30); send_high(20); send_low(30);
        checks++; if (bit_count !== 8'd3) begin
            errors++; $display("FAIL midreset_pre_count: got %0d expected 3", bit_count); end
        digital_in = 1'b1;
        repeat (10) @(negedge clk);
        v0 = n_valid; s0 = n_start; e0 = n_end; r0 = n_err;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        digital_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (n_valid - v0 + n_start - s0 + n_end - e0 + n_err - r0 != 0 || busy !== 1'b0 || bit_count !== 8'd0) begin
            errors++; $display("FAIL midreset_quiet: got events=%0d busy=%b count=%0d expected 0 0 0", n_valid - v0 + n_start - s0 + n_end - e0 + n_err - r0, busy, bit_count); end
        rst_n = 1'b1;
        send_low(10);
        send_high(60); send_low(30); send_high(20); send_low(GAP_CYCLES + 10);
        idx = v0;
        checks++; if (n_start - s0 != 1 || n_valid - v0 != 2 || bit_count !== 8'd2 || bit_log[idx[7:0]] !== 1'b1) begin
            errors++; $display("FAIL midreset_new_frame: got start=%0d bits=%0d count=%0d expected 1 2 2", n_start - s0, n_valid - v0, bit_count); end
        checks++; if (n_end - e0 != 1 || n_err - r0 != 0) begin
            errors++; $display("FAIL midreset_end: got end=%0d err=%0d expected 1 0", n_end - e0, n_err - r0); end
    endtask

    task automatic test_glitch();
        int v0 = n_valid, e0 = n_end, r0 = n_err;
        int exp_bits = FILT ? 2 : 1;
        int exp_err  = FILT ? 0 : 1;
        int exp_end  = FILT ? 1 : 0;
        send_high(20); send_low(15);
        send_high(1);  send_low(14);
        send_high(60); send_low(GAP_CYCLES + 10);
        checks++; if (n_valid - v0 != exp_bits || n_err - r0 != exp_err || n_end - e0 != exp_end) begin
            errors++; $display("FAIL glitch: got bits=%0d err=%0d end=%0d expected %0d %0d %0d", n_valid - v0, n_err - r0, n_end - e0, exp_bits, exp_err, exp_end); end
    endtask

    task automatic test_exclusive();
        checks++; if (n_both != 0 || n_start_alone != 0) begin
            errors++; $display("FAIL strobe_exclusive: got end&err=%0d start_without_bit=%0d expected 0 0", n_both, n_start_alone); end
    endtask

    initial begin
        rst_n = 1'b0;
        digital_in = 1'b0;
        test_reset();
        test_basic();
        test_widths();
        test_overlong();
        test_gap_boundary();
        test_reset_midframe();
        test_glitch();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
